// File: rtl/bcd_addsub_serial_pkg.sv
// Shared definitions for the serial BCD adder/subtractor.
package bcd_addsub_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_CORR = 4'd6;

  // True when a nibble is not a legal BCD digit.
  function automatic logic bcd_bad_digit(input logic [3:0] d);
    return d > BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit_alu.sv
// One BCD digit adder; optionally adds the nines' complement of y.
module bcd_digit_alu
  import bcd_addsub_serial_pkg::*;
(
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  input  logic       compl,
  output logic [3:0] s,
  output logic       cout
);

  logic [3:0] yy;
  logic [4:0] raw;

  // Binary digit sum followed by decimal correction when it exceeds nine.
  always_comb begin
    yy   = compl ? (BCD_MAX - y) : y;
    raw  = {1'b0, x} + {1'b0, yy} + {4'b0000, cin};
    s    = raw[3:0];
    cout = 1'b0;
    if (raw > {1'b0, BCD_MAX}) begin
      s    = raw[3:0] + BCD_CORR;
      cout = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_addsub_serial.sv
// Digit-serial BCD add/subtract, LSD first, with 10's-complement fix-up
// pass for negative differences.
module bcd_addsub_serial
  import bcd_addsub_serial_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  m,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   f,
  output logic                  cout,
  output logic                  neg,
  output logic                  err
);

  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  state_t              state, state_nx;
  logic [4*DIGITS-1:0] a_r, b_r;
  logic                m_r;
  logic [IW-1:0]       idx;
  logic                carry;
  logic                bad;
  logic                last;
  logic [3:0]          alu_x, alu_y, alu_s;
  logic                alu_compl, alu_c;

  assign last = (idx == LAST);

  // Flag any operand nibble that is not a valid BCD digit.
  always_comb begin
    bad = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_bad_digit(a[4*i +: 4]) || bcd_bad_digit(b[4*i +: 4])) bad = 1'b1;
    end
  end

  // The single digit ALU: operands in ADD, complement of the raw result in FIX.
  always_comb begin
    alu_x     = a_r[{idx, 2'b00} +: 4];
    alu_y     = b_r[{idx, 2'b00} +: 4];
    alu_compl = m_r;
    if (state == FIX) begin
      alu_x     = '0;
      alu_y     = f[{idx, 2'b00} +: 4];
      alu_compl = 1'b1;
    end
  end

  bcd_digit_alu u_alu (
    .x     (alu_x),
    .y     (alu_y),
    .cin   (carry),
    .compl (alu_compl),
    .s     (alu_s),
    .cout  (alu_c)
  );

  // Next-state and status decode.
  always_comb begin
    state_nx = state;
    busy     = (state != IDLE);
    done     = (state == DONE);
    case (state)
      IDLE: if (start) state_nx = bad ? DONE : ADD;
      ADD:  if (last)  state_nx = (m_r && !alu_c) ? FIX : DONE;
      FIX:  if (last)  state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Operand capture, digit index/carry and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r   <= '0;
      b_r   <= '0;
      m_r   <= 1'b0;
      idx   <= '0;
      carry <= 1'b0;
      f     <= '0;
      cout  <= 1'b0;
      neg   <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_r   <= a;
          b_r   <= b;
          m_r   <= m;
          idx   <= '0;
          carry <= m;  // subtract seeds the 10's-complement carry
          f     <= '0;
          cout  <= 1'b0;
          neg   <= 1'b0;
          err   <= bad;
        end
        ADD: begin
          f[{idx, 2'b00} +: 4] <= alu_s;
          carry                <= alu_c;
          if (last) begin
            idx <= '0;
            if (!m_r) cout <= alu_c;
            else if (!alu_c) begin
              // No end-around carry: result is negative, re-seed for FIX.
              neg   <= 1'b1;
              carry <= 1'b1;
            end
          end else begin
            idx <= idx + 1'b1;
          end
        end
        FIX: begin
          f[{idx, 2'b00} +: 4] <= alu_s;
          carry                <= alu_c;
          idx                  <= last ? '0 : idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
